seg_scan_multi: RTL

//  Parametrised time-multiplexed 7-segment scan driver for the lock front panel; successor to the

---
 rtl/seg_scan_multi.sv | 139 +++++++++++++
 1 files changed

// File: rtl/seg_scan_multi.sv
// seg_scan_multi: time-multiplexed 7-segment scan driver. One digit owns the
// display per slot of SCAN_DIV clocks. The first DEADTIME clocks of each slot
// keep every digit select off to suppress ghosting. Digit inputs are sampled
// once at slot start and held for the whole slot. Every output is a flop.
module seg_scan_multi #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_DIV    = 6250,
  parameter int DEADTIME    = 2,
  parameter int BLINK_SLOTS = 4000,
  parameter int HEX_EN      = 1,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [4*NUM_DIGITS-1:0]                           digits_i,
  input  logic [NUM_DIGITS-1:0]                             dp_i,
  input  logic [NUM_DIGITS-1:0]                             en_i,
  input  logic [NUM_DIGITS-1:0]                             blink_i,
  output logic [NUM_DIGITS-1:0]                             wei,
  output logic [7:0]                                        duan,
  output logic [$clog2((NUM_DIGITS > 1) ? NUM_DIGITS : 2)-1:0] scan_idx,
  output logic                                              frame_done
);

  localparam int IDX_W = $clog2((NUM_DIGITS > 1) ? NUM_DIGITS : 2);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int BLK_W = $clog2((BLINK_SLOTS > 1) ? BLINK_SLOTS : 2);

  localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_CNT = DIV_W'(DEADTIME);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLINK_SLOTS - 1);

  // XOR masks that turn the active-high form into the panel polarity; they
  // double as the "everything off" value.
  localparam logic [NUM_DIGITS-1:0] WEI_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]            DUAN_OFF = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  // running is low only for the cycle after reset, so the edge leaving reset
  // acts as a slot start without needing a tick.
  logic             running;
  logic [DIV_W-1:0] div_cnt;
  logic [BLK_W-1:0] blink_cnt;
  logic             blink_ph;

  logic             tick;
  logic             slot_start;
  logic [DIV_W-1:0] div_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [3:0]       code;
  logic [6:0]       seg7;
  logic             blank;
  logic [7:0]       seg_byte;
  logic [NUM_DIGITS-1:0] sel_nxt;

  // Slot sequencing and the byte for the digit about to own the display.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tick       = running && (div_cnt == LAST_DIV);
    slot_start = !running || tick;
    div_nxt    = slot_start ? '0 : div_cnt + 1'b1;
    idx_nxt    = scan_idx;
    if (!running)
      idx_nxt = '0;
    else if (tick)
      idx_nxt = (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;

    code = digits_i[4*int'(idx_nxt) +: 4];
    seg7 = 7'h00;
    case (code)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = (HEX_EN != 0) ? 7'h77 : 7'h00;
      4'hB: seg7 = (HEX_EN != 0) ? 7'h7C : 7'h00;
      4'hC: seg7 = (HEX_EN != 0) ? 7'h39 : 7'h00;
      4'hD: seg7 = (HEX_EN != 0) ? 7'h5E : 7'h00;
      4'hE: seg7 = (HEX_EN != 0) ? 7'h79 : 7'h00;
      default: seg7 = (HEX_EN != 0) ? 7'h71 : 7'h00;
    endcase

    // blink_ph is the registered phase, so a toggle on this tick is seen
    // from the following slot start onward.
    blank    = !en_i[idx_nxt] || (blink_i[idx_nxt] && blink_ph);
    seg_byte = blank ? 8'h00 : {dp_i[idx_nxt], seg7};
    sel_nxt  = NUM_DIGITS'(1) << idx_nxt;
  end

  // Counters, blink phase and registered outputs, with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // from pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      running    <= 1'b0;
      div_cnt    <= '0;
      scan_idx   <= '0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      frame_done <= 1'b0;
      wei        <= WEI_OFF;
      duan       <= DUAN_OFF;
    end else begin
      running  <= 1'b1;
      div_cnt  <= div_nxt;
      scan_idx <= idx_nxt;

      if (tick) begin
        if (blink_cnt == LAST_BLK) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      // High during the last cycle of the last digit's slot.
      frame_done <= (div_nxt == LAST_DIV) && (idx_nxt == LAST_IDX);

      // duan changes only at slot start; wei is off at slot start and turns
      // on once the dead time has elapsed, so both always refer to one digit.
      if (slot_start)
        duan <= seg_byte ^ DUAN_OFF;

      if (div_nxt == DEAD_CNT)
        wei <= sel_nxt ^ WEI_OFF;
      else if (slot_start)
        wei <= WEI_OFF;
    end
  end

endmodule
